window_min_max: RTL
===================

// Module: window_min_max
// PURPOSE
//  Streaming consumer of unsigned words: tracks running max and min over a window
//  of win_len accepted samples (or fewer on flush) and presents one result record.
//  Uses the same unsigned a>b / a<b magnitude compares as our comparator block.
//  Sits downstream of sample sources and feeds threshold/decision logic.
// PARAMETERS
//  word_size  32  width of in_data, out_max, out_min
//  win_len    8   samples per window; legal range 2..255
//  cnt_width  8   width of out_count/out_*_idx; must satisfy win_len <= 2**cnt_width-1
// PORTS
//  clk          in   1          rising-edge clock, single domain
//  rst_n        in   1          synchronous reset, active low
//  in_valid     in   1          in_data valid
//  in_ready     out  1          block accepts in_data this cycle
//  in_data      in   word_size  unsigned sample
//  flush        in   1          close current window early
//  out_valid    out  1          result record valid
//  out_ready    in   1          consumer takes result
//  out_max      out  word_size  largest sample in window
//  out_min      out  word_size  smallest sample in window
//  out_max_idx  out  cnt_width  window index (0-based) of first occurrence of max
//  out_min_idx  out  cnt_width  window index (0-based) of first occurrence of min
//  out_count    out  cnt_width  samples in window (1..win_len)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE; out_valid, out_max, out_min,
//    out_*_idx, out_count all 0; partial window discarded. in_ready=0 while rst_n=0.
//  - Accept = in_valid & in_ready. in_ready = rst_n & (state != HOLD).
//  - States: IDLE (window empty), ACC (1..win_len-1 samples), HOLD (result shown).
//  - IDLE, accept: max=min=in_data, both idx=0, count=1 -> ACC.
//    flush in IDLE without accept: ignored (no empty records).
//  - ACC, accept: in_data > max -> max=in_data, max_idx=count; in_data < min ->
//    min=in_data, min_idx=count; strict compares, ties keep earliest index;
//    count=count+1. If new count==win_len -> HOLD.
//  - ACC, flush (no accept): -> HOLD with current count.
//  - Same cycle accept+flush (ACC or IDLE): sample included first, then -> HOLD.
//  - HOLD: out_valid=1, all out_* stable; no input accepted. out_ready=1 ->
//    out_valid=0 and state IDLE next cycle; flush in HOLD ignored.
//  - Latency: out_valid rises the cycle after the closing accept/flush.
//    One-cycle in_ready bubble after each window (HOLD), plus any out_ready stall.
//  - Compares unsigned, full word_size; no overflow (count bounded by win_len).
//  - out_* hold last record after handshake until overwritten at next HOLD entry;
//    consumers qualify with out_valid only.
//  - Reset mid-window or mid-HOLD: record dropped, back to IDLE, no out_valid.
// TESTING
//  1 win_len=4, feed 5,9,2,9 back-to-back, out_ready=1 -> out_valid 1 cycle after
//    4th accept: max=9 idx=1, min=2 idx=2, count=4; in_ready=0 that cycle only.
//  2 Feed 7,3 then flush=1 with no valid -> max=7 idx0, min=3 idx1, count=2.
//  3 Feed 0xFFFFFFFF,0 with flush on 2nd accept -> max=0xFFFFFFFF, min=0, count=2
//    (unsigned, same-cycle flush includes sample).
//  4 out_ready=0 for 5 cycles in HOLD -> out_* stable, in_ready=0, in_valid samples
//    not consumed; release -> next window starts with first pending sample, idx 0.
//  5 All-equal window 6,6,6,6 -> max=min=6, both idx=0; flush in IDLE -> no record.
//  6 Assert rst_n=0 after 2 accepts -> no out_valid; next window counts from 1.

Source files
------------

// File: rtl/window_min_max.sv
// Streaming windowed min/max tracker: accumulates up to win_len accepted
// unsigned samples (or fewer on flush) and presents one result record.
module window_min_max #(
  parameter int unsigned word_size = 32,
  parameter int unsigned win_len   = 8,
  parameter int unsigned cnt_width = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [word_size-1:0] in_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [word_size-1:0] out_max,
  output logic [word_size-1:0] out_min,
  output logic [cnt_width-1:0] out_max_idx,
  output logic [cnt_width-1:0] out_min_idx,
  output logic [cnt_width-1:0] out_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [cnt_width-1:0] win_cnt = cnt_width'(win_len);

  state_t               state;
  logic [word_size-1:0] acc_max;
  logic [word_size-1:0] acc_min;
  logic [cnt_width-1:0] acc_max_idx;
  logic [cnt_width-1:0] acc_min_idx;
  logic [cnt_width-1:0] acc_count;

  logic [word_size-1:0] upd_max;
  logic [word_size-1:0] upd_min;
  logic [cnt_width-1:0] upd_max_idx;
  logic [cnt_width-1:0] upd_min_idx;
  logic [cnt_width-1:0] upd_count;

  logic [word_size-1:0] rec_max;
  logic [word_size-1:0] rec_min;
  logic [cnt_width-1:0] rec_max_idx;
  logic [cnt_width-1:0] rec_min_idx;
  logic [cnt_width-1:0] rec_count;

  logic accept;
  logic close;

  // Input handshake: blocked while the result record is on display or in reset
  assign in_ready = rst_n & (state != HOLD);
  assign accept   = in_valid & in_ready;

  // Window statistics after folding in the current sample (strict compares keep earliest index on ties)
  always_comb begin
    upd_max     = acc_max;
    upd_min     = acc_min;
    upd_max_idx = acc_max_idx;
    upd_min_idx = acc_min_idx;
    upd_count   = acc_count + cnt_width'(1);
    if (state == IDLE) begin
      upd_max     = in_data;
      upd_min     = in_data;
      upd_max_idx = '0;
      upd_min_idx = '0;
      upd_count   = cnt_width'(1);
    end else begin
      if (in_data > acc_max) begin
        upd_max     = in_data;
        upd_max_idx = acc_count;
      end
      if (in_data < acc_min) begin
        upd_min     = in_data;
        upd_min_idx = acc_count;
      end
    end
  end

  // Window-closing decision and the record that would be published
  always_comb begin
    close       = 1'b0;
    rec_max     = acc_max;
    rec_min     = acc_min;
    rec_max_idx = acc_max_idx;
    rec_min_idx = acc_min_idx;
    rec_count   = acc_count;
    if (accept) begin
      close       = flush | (upd_count == win_cnt);
      rec_max     = upd_max;
      rec_min     = upd_min;
      rec_max_idx = upd_max_idx;
      rec_min_idx = upd_min_idx;
      rec_count   = upd_count;
    end else if (state == ACC) begin
      close = flush;
    end
  end

  // State, accumulator and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_max     <= '0;
      out_min     <= '0;
      out_max_idx <= '0;
      out_min_idx <= '0;
      out_count   <= '0;
      acc_max     <= '0;
      acc_min     <= '0;
      acc_max_idx <= '0;
      acc_min_idx <= '0;
      acc_count   <= '0;
    end else begin
      if (accept) begin
        acc_max     <= upd_max;
        acc_min     <= upd_min;
        acc_max_idx <= upd_max_idx;
        acc_min_idx <= upd_min_idx;
        acc_count   <= upd_count;
      end
      if (close) begin
        state       <= HOLD;
        out_valid   <= 1'b1;
        out_max     <= rec_max;
        out_min     <= rec_min;
        out_max_idx <= rec_max_idx;
        out_min_idx <= rec_min_idx;
        out_count   <= rec_count;
      end else if (accept) begin
        state <= ACC;
      end else if (state == HOLD && out_ready) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end
    end
  end

endmodule
